// File: rtl/register_file_mp.sv
// Multi-port register file with per-register busy scoreboard; combinational reads, synchronous writes.
// Build option RF_FORWARD_EN: same-cycle write-to-read bypass of data and busy.
module register_file_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD*DATA_W-1:0]  rd_data,
  output logic [NUM_RD-1:0]         rd_busy,
  input  logic [NUM_WR-1:0]         wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]  wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]  wr_data,
  input  logic                      set_en,
  input  logic [ADDR_W-1:0]         set_dest,
  input  logic                      flush,
  output logic [(1<<ADDR_W)-1:0]    busy_vec
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs    [DEPTH];
  logic [DATA_W-1:0] wr_val  [DEPTH];
  logic [DEPTH-1:0]  wr_hit;
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;

  // Per-register write select; ascending scan lets the highest-index port win a collision.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_val[i] = '0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(i))) begin
          wr_hit[i] = 1'b1;
          wr_val[i] = wr_data[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= DATA_W'(i);
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_hit[i]) begin
          regs[i] <= wr_val[i];
        end
      end
    end
  end

  // Scoreboard priority: flush, then issue-set, then writeback-clear.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush) begin
        busy_nxt[i] = 1'b0;
      end else if (set_en && (set_dest == ADDR_W'(i))) begin
        busy_nxt[i] = 1'b1;
      end else if (wr_hit[i]) begin
        busy_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign busy_vec = busy;

  genvar k;
  generate
    for (k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      assign ra = rd_addr[k*ADDR_W +: ADDR_W];

`ifdef RF_FORWARD_EN
      always_comb begin
        rd_data[k*DATA_W +: DATA_W] = regs[ra];
        rd_busy[k]                  = busy[ra];
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == ra)) begin
            rd_data[k*DATA_W +: DATA_W] = wr_data[w*DATA_W +: DATA_W];
            rd_busy[k]                  = 1'b0;
          end
        end
      end
`else
      always_comb begin
        rd_data[k*DATA_W +: DATA_W] = regs[ra];
        rd_busy[k]                  = busy[ra];
      end
`endif
    end
  endgenerate

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp (NUM_RD=2, NUM_WR=2) with a scoreboard of expected outputs.
module tb_register_file_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;

  localparam int K_DATA = 0;
  localparam int K_BUSY = 1;
  localparam int K_VEC  = 2;

  logic                     clk;
  logic                     rst;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     set_en;
  logic [ADDR_W-1:0]        set_dest;
  logic                     flush;
  logic [15:0]              busy_vec;

  register_file_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .set_en(set_en), .set_dest(set_dest), .flush(flush),
    .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic exp_push(input string tag, input int kind, input int port, input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.port = port;
    e.val  = val;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int kind, input int port);
    case (kind)
      K_DATA:  return rd_data[port*DATA_W +: DATA_W];
      K_BUSY:  return {31'b0, rd_busy[port]};
      default: return {16'b0, busy_vec};
    endcase
  endfunction

  // Compare every pending expectation against the settled DUT outputs.
  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.kind, e.port);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {4'(a1), 4'(a0)};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en    = '0;
    set_en   = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    rd_addr  = '0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    set_en   = 1'b0;
    set_dest = '0;
    flush    = 1'b0;

    // 1. asynchronous reset, asserted and released mid-cycle
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    set_rd(3, 15);
    #1;
    exp_push("rst_in_reg3", K_DATA, 0, 32'd3);
    exp_push("rst_in_reg15", K_DATA, 1, 32'd15);
    exp_push("rst_in_vec", K_VEC, 0, 32'd0);
    exp_push("rst_in_busy0", K_BUSY, 0, 32'd0);
    drain();
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      set_rd(i, 15 - i);
      #1;
      exp_push($sformatf("rst_reg%0d", i), K_DATA, 0, 32'(i));
      exp_push($sformatf("rst_reg%0d_p1", 15 - i), K_DATA, 1, 32'(15 - i));
      exp_push("rst_busy0", K_BUSY, 0, 32'd0);
      exp_push("rst_busy1", K_BUSY, 1, 32'd0);
      drain();
    end
    exp_push("rst_vec", K_VEC, 0, 32'd0);
    drain();

    // 2. single write, same-cycle and next-cycle read
    tick();
    set_rd(5, 3);
    wr_en   = 2'b01;
    wr_addr = {4'd0, 4'd5};
    wr_data = {32'h0, 32'hDEAD_BEEF};
    #1;
`ifdef RF_FORWARD_EN
    exp_push("wr5_same_cycle_fwd", K_DATA, 0, 32'hDEAD_BEEF);
`else
    exp_push("wr5_same_cycle_old", K_DATA, 0, 32'd5);
`endif
    exp_push("wr5_other_port", K_DATA, 1, 32'd3);
    drain();
    tick();
    idle_inputs();
    #1;
    exp_push("wr5_after_edge", K_DATA, 0, 32'hDEAD_BEEF);
    exp_push("wr5_busy_stays0", K_VEC, 0, 32'd0);
    drain();

    // 3. collision on reg7: port1 wins
    wr_en   = 2'b11;
    wr_addr = {4'd7, 4'd7};
    wr_data = {32'h2222, 32'h1111};
    set_rd(7, 7);
    #1;
`ifdef RF_FORWARD_EN
    exp_push("coll7_fwd", K_DATA, 0, 32'h2222);
    drain();
`endif
    tick();
    idle_inputs();
    #1;
    exp_push("coll7_p0", K_DATA, 0, 32'h2222);
    exp_push("coll7_p1", K_DATA, 1, 32'h2222);
    drain();

    // 3b. two ports to distinct registers in one cycle
    wr_en   = 2'b11;
    wr_addr = {4'd12, 4'd1};
    wr_data = {32'hC0C0_0012, 32'hA5A5_0001};
    tick();
    idle_inputs();
    set_rd(1, 12);
    #1;
    exp_push("dual_wr1", K_DATA, 0, 32'hA5A5_0001);
    exp_push("dual_wr12", K_DATA, 1, 32'hC0C0_0012);
    drain();

    // 4. scoreboard set, clear by write, set+write same cycle
    set_en   = 1'b1;
    set_dest = 4'd9;
    tick();
    idle_inputs();
    set_rd(9, 3);
    #1;
    exp_push("set9_vec", K_VEC, 0, 32'h0000_0200);
    exp_push("set9_rdbusy", K_BUSY, 0, 32'd1);
    exp_push("set9_other_rdbusy", K_BUSY, 1, 32'd0);
    drain();
    wr_en   = 2'b01;
    wr_addr = {4'd0, 4'd9};
    wr_data = {32'h0, 32'h0000_0099};
    #1;
`ifdef RF_FORWARD_EN
    exp_push("wr9_busy_fwd", K_BUSY, 0, 32'd0);
`else
    exp_push("wr9_busy_reg", K_BUSY, 0, 32'd1);
`endif
    drain();
    tick();
    idle_inputs();
    #1;
    exp_push("clr9_vec", K_VEC, 0, 32'd0);
    exp_push("clr9_data", K_DATA, 0, 32'h0000_0099);
    drain();
    set_en   = 1'b1;
    set_dest = 4'd9;
    wr_en    = 2'b10;
    wr_addr  = {4'd9, 4'd0};
    wr_data  = {32'h0000_00AA, 32'h0};
    tick();
    idle_inputs();
    #1;
    exp_push("setwr9_vec", K_VEC, 0, 32'h0000_0200);
    exp_push("setwr9_data", K_DATA, 0, 32'h0000_00AA);
    drain();
    set_en   = 1'b1;
    set_dest = 4'd10;
    wr_en    = 2'b01;
    wr_addr  = {4'd0, 4'd11};
    wr_data  = {32'h0, 32'h0000_0B0B};
    tick();
    idle_inputs();
    set_rd(11, 10);
    #1;
    exp_push("indep_vec", K_VEC, 0, 32'h0000_0600);
    exp_push("indep_data11", K_DATA, 0, 32'h0000_0B0B);
    exp_push("indep_busy10", K_BUSY, 1, 32'd1);
    drain();

    // 5. flush beats a same-cycle set
    set_en = 1'b1;
    set_dest = 4'd2;  tick();
    set_dest = 4'd4;  tick();
    set_dest = 4'd6;  tick();
    idle_inputs();
    #1;
    exp_push("pre_flush_vec", K_VEC, 0, 32'h0000_0654);
    drain();
    flush    = 1'b1;
    set_en   = 1'b1;
    set_dest = 4'd8;
    tick();
    idle_inputs();
    #1;
    exp_push("flush_vec", K_VEC, 0, 32'd0);
    drain();

    // 6. reset between a write and its edge loses the write
    set_en   = 1'b1;
    set_dest = 4'd3;
    tick();
    idle_inputs();
    wr_en   = 2'b01;
    wr_addr = {4'd0, 4'd5};
    wr_data = {32'h0, 32'h5555_5555};
    #2 rst = 1'b0;
    #1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    set_rd(5, 7);
    #1;
    exp_push("rst2_reg5", K_DATA, 0, 32'd5);
    exp_push("rst2_reg7", K_DATA, 1, 32'd7);
    exp_push("rst2_vec", K_VEC, 0, 32'd0);
    drain();
    set_rd(9, 1);
    #1;
    exp_push("rst2_reg9", K_DATA, 0, 32'd9);
    exp_push("rst2_reg1", K_DATA, 1, 32'd1);
    drain();
    tick();
    set_rd(15, 11);
    #1;
    exp_push("rst2_reg15", K_DATA, 0, 32'd15);
    exp_push("rst2_reg11", K_DATA, 1, 32'd11);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
